fpga_top: RTL and testbench



---
 rtl/fpga_top_pkg.sv | 52 +++++
 rtl/keypad_scanner.sv | 73 +++++++
 rtl/fpga_top.sv | 151 +++++++++++++++
 tb/tb_fpga_top.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_top_pkg.sv
// Shared key codes, display/LCD encodings and the LCD controller state type
// for the front-panel design.
package fpga_top_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_HOME     = 8'h80;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WRITE, ST_HOME} lcd_state_t;

  // Segment order {dp,g,f,e,d,c,b,a}, active-high
  function automatic logic [7:0] seg_pattern(input logic [3:0] code);
    case (code)
      4'd0:     seg_pattern = 8'h3F;
      4'd1:     seg_pattern = 8'h06;
      4'd2:     seg_pattern = 8'h5B;
      4'd3:     seg_pattern = 8'h4F;
      4'd4:     seg_pattern = 8'h66;
      4'd5:     seg_pattern = 8'h6D;
      4'd6:     seg_pattern = 8'h7D;
      4'd7:     seg_pattern = 8'h07;
      4'd8:     seg_pattern = 8'h7F;
      4'd9:     seg_pattern = 8'h6F;
      KEY_STAR: seg_pattern = 8'h40;
      KEY_HASH: seg_pattern = 8'h76;
      default:  seg_pattern = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] key_ascii(input logic [3:0] code);
    case (code)
      KEY_STAR: key_ascii = 8'h2A;
      KEY_HASH: key_ascii = 8'h23;
      default:  key_ascii = 8'h30 + {4'h0, code};
    endcase
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = LCD_FUNC_SET;
      2'd1:    init_cmd = LCD_DISP_ON;
      2'd2:    init_cmd = LCD_ENTRY;
      default: init_cmd = LCD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 3x4 keypad row scanner: drives one row low per dwell, samples columns at the
// end of the dwell and emits one key event per press (release = one clean scan).
module keypad_scanner
  import fpga_top_pkg::*;
#(
  parameter int SCAN_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cols_i,
  output logic [3:0] rows_o,
  output logic       key_valid_o,
  output logic [3:0] key_code_o
);

  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_q;
  logic [1:0]    row_q;
  logic          seen_cur_q, seen_prev_q;
  logic          key_valid_q;
  logic [3:0]    key_code_q;
  logic          hit;
  logic [1:0]    col;
  logic [3:0]    code_now;

  always_comb begin
    hit = (cols_i != 3'b111);
    if (!cols_i[0])      col = 2'd0;
    else if (!cols_i[1]) col = 2'd1;
    else                 col = 2'd2;
    if (row_q == 2'd3)
      code_now = (col == 2'd0) ? KEY_STAR : (col == 2'd1) ? 4'd0 : KEY_HASH;
    else
      code_now = 4'(row_q) * 4'd3 + 4'(col) + 4'd1;
  end

  // seen_prev_q summarises the last complete 4-row scan; only a clean scan re-arms events
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      row_q       <= 2'd0;
      seen_cur_q  <= 1'b0;
      seen_prev_q <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      key_valid_q <= 1'b0;
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        row_q <= row_q + 2'd1;
        if (hit && !seen_prev_q) begin
          key_valid_q <= 1'b1;
          key_code_q  <= code_now;
        end
        if (row_q == 2'd3) begin
          seen_prev_q <= seen_cur_q | hit;
          seen_cur_q  <= 1'b0;
        end else begin
          seen_cur_q  <= seen_cur_q | hit;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign rows_o      = ~(4'b0001 << row_q);
  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;

endmodule

// File: rtl/fpga_top.sv
// Front panel top: keypad scanner, LED heartbeat, 8-digit 7-seg history of the
// last keys and an HD44780 write-only echo of each key.
module fpga_top
  import fpga_top_pkg::*;
#(
  parameter int LED_DIV  = 2000000,
  parameter int SCAN_DIV = 50,
  parameter int SEG_DIV  = 1000,
  parameter int LCD_DIV  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_from_keypad,
  output logic [3:0] out_to_keypad,
  output logic [7:0] out_to_led,
  output logic [7:0] out_to_seg_data,
  output logic [7:0] out_to_seg_en,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int LW = $clog2(LED_DIV + 1);
  localparam int GW = $clog2(SEG_DIV + 1);
  localparam int SW = $clog2(LCD_DIV + 1);
  localparam logic [LW-1:0] LED_LAST  = LW'(LED_DIV - 1);
  localparam logic [GW-1:0] SEG_LAST  = GW'(SEG_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(LCD_DIV - 1);
  localparam logic [SW-1:0] E_END     = SW'(LCD_DIV / 2);

  logic       key_valid;
  logic [3:0] key_code;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_kp (
    .clk         (clk),
    .rst         (rst),
    .cols_i      (in_from_keypad),
    .rows_o      (out_to_keypad),
    .key_valid_o (key_valid),
    .key_code_o  (key_code)
  );

  logic [LW-1:0] led_div_q;
  logic [7:0]    led_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      led_div_q <= '0;
      led_q     <= 8'h01;
    end else if (led_div_q == LED_LAST) begin
      led_div_q <= '0;
      led_q     <= {led_q[6:0], led_q[7]};
    end else begin
      led_div_q <= led_div_q + 1'b1;
    end
  end

  logic [GW-1:0]   seg_div_q;
  logic [2:0]      dig_q, dig_d;
  logic [7:0][3:0] dig_code_q;
  logic [7:0]      dig_vld_q;
  logic [7:0]      seg_data_q;

  assign dig_d = (seg_div_q == SEG_LAST) ? dig_q + 3'd1 : dig_q;

  // Pattern is looked up for the next digit so data and enable change on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_div_q  <= '0;
      dig_q      <= 3'd0;
      dig_code_q <= '0;
      dig_vld_q  <= 8'h00;
      seg_data_q <= 8'h00;
    end else begin
      seg_div_q  <= (seg_div_q == SEG_LAST) ? '0 : seg_div_q + 1'b1;
      dig_q      <= dig_d;
      seg_data_q <= dig_vld_q[dig_d] ? seg_pattern(dig_code_q[dig_d]) : 8'h00;
      if (key_valid) begin
        dig_code_q <= {dig_code_q[6:0], key_code};
        dig_vld_q  <= {dig_vld_q[6:0], 1'b1};
      end
    end
  end

  lcd_state_t st_q;
  logic [SW-1:0] slot_q;
  logic [1:0]    init_idx_q;
  logic [3:0]    col_q;
  logic [7:0]    char_q;
  logic          e_q, rs_q;
  logic [7:0]    data_q;
  logic          slot_e;

  assign slot_e = (slot_q != '0) && (slot_q <= E_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_INIT;
      slot_q     <= '0;
      init_idx_q <= 2'd0;
      col_q      <= 4'd0;
      char_q     <= 8'h00;
      e_q        <= 1'b0;
      rs_q       <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      case (st_q)
        ST_IDLE: begin
          slot_q <= '0;
          e_q    <= 1'b0;
          if (key_valid) begin
            char_q <= key_ascii(key_code);
            st_q   <= ST_WRITE;
          end
        end
        default: begin
          e_q    <= slot_e;
          rs_q   <= (st_q == ST_WRITE);
          data_q <= (st_q == ST_INIT)  ? init_cmd(init_idx_q) :
                    (st_q == ST_WRITE) ? char_q : LCD_HOME;
          if (slot_q == SLOT_LAST) begin
            slot_q <= '0;
            case (st_q)
              ST_INIT: begin
                if (init_idx_q == 2'd3) st_q <= ST_IDLE;
                init_idx_q <= init_idx_q + 2'd1;
              end
              ST_WRITE: begin
                col_q <= col_q + 4'd1;
                st_q  <= (col_q == 4'd15) ? ST_HOME : ST_IDLE;
              end
              default: st_q <= ST_IDLE;
            endcase
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign out_to_led      = led_q;
  assign out_to_seg_data = seg_data_q;
  assign out_to_seg_en   = ~(8'b0000_0001 << dig_q);
  assign lcd_e           = e_q;
  assign lcd_rw          = 1'b0;
  assign lcd_rs          = rs_q;
  assign lcd_data        = data_q;

endmodule

// File: tb/tb_fpga_top.sv
// Directed bench for fpga_top with shortened dividers and a behavioural keypad.
module tb_fpga_top;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_from_keypad;
  logic [3:0] out_to_keypad;
  logic [7:0] out_to_led, out_to_seg_data, out_to_seg_en, lcd_data;
  logic       lcd_e, lcd_rw, lcd_rs;

  fpga_top #(.LED_DIV(20), .SCAN_DIV(10), .SEG_DIV(8), .LCD_DIV(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_from_keypad  (in_from_keypad),
    .out_to_keypad   (out_to_keypad),
    .out_to_led      (out_to_led),
    .out_to_seg_data (out_to_seg_data),
    .out_to_seg_en   (out_to_seg_en),
    .lcd_e           (lcd_e),
    .lcd_rw          (lcd_rw),
    .lcd_rs          (lcd_rs),
    .lcd_data        (lcd_data)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       key_on = 1'b0;
  logic [1:0] key_row = 2'd0, key_col = 2'd0;

  // Pressed key shorts its row to its column
  always_comb
    in_from_keypad = (key_on && out_to_keypad == ~(4'b0001 << key_row)) ?
                     ~(3'b001 << key_col) : 3'b111;

  int         ev_cnt = 0;
  logic [3:0] last_code = 4'd0;
  logic [8:0] lcd_rec[$];
  int         e_len[$];
  int         e_run = 0;
  logic       e_prev = 1'b0;

  always @(negedge clk) begin
    if (dut.key_valid === 1'b1) begin
      ev_cnt++;
      last_code = dut.key_code;
    end
    if (lcd_e === 1'b1 && !e_prev) lcd_rec.push_back({lcd_rs, lcd_data});
    if (lcd_e === 1'b1) e_run++;
    else if (e_prev) begin
      e_len.push_back(e_run);
      e_run = 0;
    end
    e_prev = (lcd_e === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c, input int hold, input int rel);
    key_row = r;
    key_col = c;
    key_on  = 1'b1;
    tick(hold);
    key_on  = 1'b0;
    tick(rel);
  endtask

  task automatic read_digit(input int d, output logic [7:0] v, output bit ok);
    int n = 0;
    while (out_to_seg_en !== ~(8'b0000_0001 << d) && n < 200) begin
      tick(1);
      n++;
    end
    ok = (n < 200);
    v  = out_to_seg_data;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    key_on = 1'b0;
    tick(5);
    total++; if (out_to_led !== 8'h01) begin bad++; $display("FAIL reset_led got=%h exp=01", out_to_led); end
    total++; if (out_to_keypad !== 4'b1110) begin bad++; $display("FAIL reset_kp got=%b exp=1110", out_to_keypad); end
    total++; if (out_to_seg_en !== 8'hFE) begin bad++; $display("FAIL reset_segen got=%h exp=fe", out_to_seg_en); end
    total++; if (out_to_seg_data !== 8'h00) begin bad++; $display("FAIL reset_segdata got=%h exp=00", out_to_seg_data); end
    total++; if ({lcd_e, lcd_rw, lcd_rs, lcd_data} !== 11'h000) begin bad++; $display("FAIL reset_lcd got=%b%b%b_%h exp=000_00", lcd_e, lcd_rw, lcd_rs, lcd_data); end
    lcd_rec.delete();
    e_len.delete();
    rst = 1'b0;
    tick(19);
    total++; if (out_to_led !== 8'h01) begin bad++; $display("FAIL led_19 got=%h exp=01", out_to_led); end
    tick(1);
    total++; if (out_to_led !== 8'h02) begin bad++; $display("FAIL led_20 got=%h exp=02", out_to_led); end
    tick(139);
    total++; if (out_to_led !== 8'h80) begin bad++; $display("FAIL led_159 got=%h exp=80", out_to_led); end
    tick(1);
    total++; if (out_to_led !== 8'h01) begin bad++; $display("FAIL led_wrap got=%h exp=01", out_to_led); end
  endtask

  task automatic test_lcd_init;
    logic [8:0] exp_init[4] = '{9'h038, 9'h00C, 9'h006, 9'h001};
    total++; if (lcd_rec.size() != 4) begin bad++; $display("FAIL init_count got=%0d exp=4", lcd_rec.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (lcd_rec.size() <= i || lcd_rec[i] !== exp_init[i]) begin bad++; $display("FAIL init_cmd%0d got=%h exp=%h", i, (lcd_rec.size() > i) ? lcd_rec[i] : 9'h1FF, exp_init[i]); end
      total++; if (e_len.size() <= i || e_len[i] != 4) begin bad++; $display("FAIL init_ewidth%0d got=%0d exp=4", i, (e_len.size() > i) ? e_len[i] : -1); end
    end
    total++; if (lcd_rw !== 1'b0) begin bad++; $display("FAIL init_rw got=%b exp=0", lcd_rw); end
  endtask

  task automatic test_key1;
    int base = lcd_rec.size();
    int ev0 = ev_cnt;
    logic [7:0] v;
    bit ok;
    press(2'd0, 2'd0, 100, 100);
    total++; if (ev_cnt - ev0 != 1) begin bad++; $display("FAIL key1_events got=%0d exp=1", ev_cnt - ev0); end
    total++; if (last_code !== 4'd1) begin bad++; $display("FAIL key1_code got=%0d exp=1", last_code); end
    read_digit(0, v, ok);
    total++; if (!ok || v !== 8'h06) begin bad++; $display("FAIL key1_seg0 got=%h exp=06", v); end
    read_digit(1, v, ok);
    total++; if (!ok || v !== 8'h00) begin bad++; $display("FAIL key1_seg1_blank got=%h exp=00", v); end
    total++; if (lcd_rec.size() != base + 1 || lcd_rec[base] !== 9'h131) begin bad++; $display("FAIL key1_lcd got=%h exp=131", lcd_rec[base]); end
  endtask

  task automatic test_keys_5_9;
    int base = lcd_rec.size();
    int ev0 = ev_cnt;
    logic [7:0] v;
    bit ok;
    press(2'd1, 2'd1, 100, 100);
    press(2'd2, 2'd2, 100, 100);
    total++; if (ev_cnt - ev0 != 2) begin bad++; $display("FAIL k59_events got=%0d exp=2", ev_cnt - ev0); end
    read_digit(2, v, ok);
    total++; if (!ok || v !== 8'h06) begin bad++; $display("FAIL k59_seg2 got=%h exp=06", v); end
    read_digit(1, v, ok);
    total++; if (!ok || v !== 8'h6D) begin bad++; $display("FAIL k59_seg1 got=%h exp=6d", v); end
    read_digit(0, v, ok);
    total++; if (!ok || v !== 8'h6F) begin bad++; $display("FAIL k59_seg0 got=%h exp=6f", v); end
    total++; if (lcd_rec.size() != base + 2 || lcd_rec[base] !== 9'h135 || lcd_rec[base+1] !== 9'h139) begin
      bad++; $display("FAIL k59_lcd got=%h,%h exp=135,139", lcd_rec[base], lcd_rec[base+1]);
    end
  endtask

  task automatic test_row3;
    logic [1:0] cols[3] = '{2'd0, 2'd2, 2'd1};
    logic [7:0] segs[3] = '{8'h40, 8'h76, 8'h3F};
    logic [8:0] lcds[3] = '{9'h12A, 9'h123, 9'h130};
    logic [7:0] v;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      int base = lcd_rec.size();
      press(2'd3, cols[i], 100, 100);
      read_digit(0, v, ok);
      total++; if (!ok || v !== segs[i]) begin bad++; $display("FAIL row3_seg c%0d got=%h exp=%h", cols[i], v, segs[i]); end
      total++; if (lcd_rec.size() != base + 1 || lcd_rec[base] !== lcds[i]) begin bad++; $display("FAIL row3_lcd c%0d got=%h exp=%h", cols[i], lcd_rec[base], lcds[i]); end
    end
  endtask

  task automatic test_held;
    int ev0 = ev_cnt;
    press(2'd0, 2'd1, 400, 90);
    total++; if (ev_cnt - ev0 != 1) begin bad++; $display("FAIL held_single got=%0d exp=1", ev_cnt - ev0); end
    press(2'd0, 2'd1, 100, 100);
    total++; if (ev_cnt - ev0 != 2) begin bad++; $display("FAIL held_repress got=%0d exp=2", ev_cnt - ev0); end
    total++; if (last_code !== 4'd2) begin bad++; $display("FAIL held_code got=%0d exp=2", last_code); end
  endtask

  // Eight chars written so far; eight more fill the line and trigger the home command
  task automatic test_lcd_home;
    int base = lcd_rec.size();
    for (int i = 0; i < 8; i++) press(2'(i / 3), 2'(i % 3), 100, 100);
    total++; if (lcd_rec.size() != base + 9) begin bad++; $display("FAIL home_count got=%0d exp=%0d", lcd_rec.size(), base + 9); end
    total++; if (lcd_rec[base+7] !== 9'h138) begin bad++; $display("FAIL home_col15 got=%h exp=138", lcd_rec[base+7]); end
    total++; if (lcd_rec[base+8] !== 9'h080) begin bad++; $display("FAIL home_cmd got=%h exp=080", lcd_rec[base+8]); end
    press(2'd0, 2'd0, 100, 100);
    total++; if (lcd_rec[base+9] !== 9'h131) begin bad++; $display("FAIL home_next got=%h exp=131", lcd_rec[base+9]); end
  endtask

  task automatic test_rst_midwrite;
    int n = 0;
    int base;
    key_row = 2'd0;
    key_col = 2'd2;
    key_on  = 1'b1;
    while (!(lcd_e === 1'b1 && lcd_rs === 1'b1) && n < 200) begin
      tick(1);
      n++;
    end
    total++; if (n >= 200) begin bad++; $display("FAIL rst_wait_strobe got=timeout exp=strobe"); end
    tick(1);
    rst = 1'b1;
    key_on = 1'b0;
    tick(1);
    total++; if (lcd_e !== 1'b0 || lcd_data !== 8'h00) begin bad++; $display("FAIL rst_abort got=e%b_%h exp=e0_00", lcd_e, lcd_data); end
    total++; if (out_to_seg_data !== 8'h00) begin bad++; $display("FAIL rst_seg got=%h exp=00", out_to_seg_data); end
    rst = 1'b0;
    base = lcd_rec.size();
    tick(40);
    total++; if (lcd_rec.size() != base + 4 || lcd_rec[base] !== 9'h038 || lcd_rec[base+3] !== 9'h001) begin
      bad++; $display("FAIL rst_reinit got=%h..%h n=%0d exp=038..001 n=4", lcd_rec[base], lcd_rec[base+3], lcd_rec.size() - base);
    end
  endtask

  initial begin
    rst = 1'b1;
    #1;
    test_reset;
    test_lcd_init;
    test_key1;
    test_keys_5_9;
    test_row3;
    test_held;
    test_lcd_home;
    test_rst_midwrite;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
